// File: rtl/exc_pkg.sv
// Shared definitions for the exception controller: cause codes, FSM
// state encoding and the priority-encoder result bundle.
package exc_pkg;

  localparam logic [4:0] CAUSE_INT = 5'd0;
  localparam logic [4:0] CAUSE_SYS = 5'd8;
  localparam logic [4:0] CAUSE_BRK = 5'd9;
  localparam logic [4:0] CAUSE_TEQ = 5'd13;

  localparam int INT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTER  = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_RETURN = 2'd3
  } exc_state_t;

  // Winner of the IDLE-state arbitration.
  typedef struct packed {
    logic       take_exc;   // exception or interrupt entry
    logic       take_eret;  // return from exception
    logic       sync;       // entry is a synchronous request (gets ack)
    logic [4:0] cause;
  } prio_sel_t;

  // An interrupt is taken only when a pending line is unmasked and IE is set.
  function automatic logic int_enabled(input logic [INT_W-1:0] pend,
                                       input logic [INT_W-1:0] im,
                                       input logic             ie);
    return ie && (|(pend & im));
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority selection of the next exception action and its cause:
// syscall > break > teq > eret > enabled interrupt.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic      syscall,
  input  logic      brk,
  input  logic      teq,
  input  logic      eret,
  input  logic      int_en,
  output prio_sel_t sel
);

  // Priority chain; first hit wins, eret only when no exception is asked for.
  always_comb begin
    sel       = '0;
    sel.cause = CAUSE_INT;
    if (syscall) begin
      sel.take_exc = 1'b1;
      sel.sync     = 1'b1;
      sel.cause    = CAUSE_SYS;
    end else if (brk) begin
      sel.take_exc = 1'b1;
      sel.sync     = 1'b1;
      sel.cause    = CAUSE_BRK;
    end else if (teq) begin
      sel.take_exc = 1'b1;
      sel.sync     = 1'b1;
      sel.cause    = CAUSE_TEQ;
    end else if (eret) begin
      sel.take_eret = 1'b1;
    end else if (int_en) begin
      sel.take_exc = 1'b1;
      sel.cause    = CAUSE_INT;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception sequencer: arbitrates requests in IDLE, then runs a fixed
// ENTER -> FLUSH sequence for exceptions or a one-cycle RETURN for eret.
// All outputs are registered and decoded from the next state.
module exc_ctrl
  import exc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        teq_i,
  input  logic        eret_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] status_i,
  output logic        exc_o,
  output logic        eret_o,
  output logic [4:0]  cause_o,
  output logic [31:0] epc_o,
  output logic        ack_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic        busy_o,
  output logic [5:0]  int_pend_o
);

  exc_state_t       state, nxt_state;
  prio_sel_t        sel;
  logic             int_en;
  logic             take_entry;
  logic [INT_W-1:0] int_clr;
  logic             n_exc, n_eret, n_ack, n_stall, n_flush, n_busy;

  // Only IE and IM participate; the remaining status bits are don't-care.
  logic unused_status;
  assign unused_status = ^{status_i[31:16], status_i[9:1]};

  assign int_en = int_enabled(int_pend_o, status_i[15:10], status_i[0]);

  exc_prio_enc u_prio (
    .syscall (syscall_i),
    .brk     (break_i),
    .teq     (teq_i),
    .eret    (eret_i),
    .int_en  (int_en),
    .sel     (sel)
  );

  // Next state plus next registered outputs; requests are only looked at in IDLE.
  always_comb begin
    nxt_state  = state;
    take_entry = 1'b0;
    n_ack      = 1'b0;
    int_clr    = '0;
    case (state)
      ST_IDLE: begin
        if (sel.take_exc) begin
          nxt_state  = ST_ENTER;
          take_entry = 1'b1;
          n_ack      = sel.sync;
          // Interrupt entry consumes every pending bit the mask lets through.
          if (!sel.sync) int_clr = status_i[15:10];
        end else if (sel.take_eret) begin
          nxt_state = ST_RETURN;
          n_ack     = 1'b1;
        end
      end
      ST_ENTER:  nxt_state = ST_FLUSH;
      ST_FLUSH:  nxt_state = ST_IDLE;
      ST_RETURN: nxt_state = ST_IDLE;
      default:   nxt_state = ST_IDLE;
    endcase
    n_exc   = (nxt_state == ST_ENTER);
    n_eret  = (nxt_state == ST_RETURN);
    n_stall = (nxt_state == ST_ENTER) || (nxt_state == ST_FLUSH);
    n_flush = (nxt_state == ST_FLUSH) || (nxt_state == ST_RETURN);
    n_busy  = (nxt_state != ST_IDLE);
  end

  // State, output, cause/epc and pending-interrupt registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      exc_o      <= 1'b0;
      eret_o     <= 1'b0;
      ack_o      <= 1'b0;
      stall_o    <= 1'b0;
      flush_o    <= 1'b0;
      busy_o     <= 1'b0;
      cause_o    <= '0;
      epc_o      <= '0;
      int_pend_o <= '0;
    end else begin
      state   <= nxt_state;
      exc_o   <= n_exc;
      eret_o  <= n_eret;
      ack_o   <= n_ack;
      stall_o <= n_stall;
      flush_o <= n_flush;
      busy_o  <= n_busy;
      if (take_entry) begin
        cause_o <= sel.cause;
        epc_o   <= pc_i;
      end
      // Clear happens after the OR, so a line still high re-sets next cycle.
      int_pend_o <= (int_pend_o | int_i) & ~int_clr;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: one task per scenario, inline checks.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_i = '0;
  logic        syscall_i = 1'b0, break_i = 1'b0, teq_i = 1'b0, eret_i = 1'b0;
  logic [5:0]  int_i = '0;
  logic [31:0] status_i = '0;
  logic        exc_o, eret_o, ack_o, stall_o, flush_o, busy_o;
  logic [4:0]  cause_o;
  logic [31:0] epc_o;
  logic [5:0]  int_pend_o;

  // {exc, eret, ack, stall, flush, busy}
  logic [5:0] ctl;
  assign ctl = {exc_o, eret_o, ack_o, stall_o, flush_o, busy_o};

  localparam logic [5:0] C_IDLE  = 6'b000000;
  localparam logic [5:0] C_ENT_S = 6'b101101;
  localparam logic [5:0] C_ENT_I = 6'b100101;
  localparam logic [5:0] C_FLUSH = 6'b000111;
  localparam logic [5:0] C_RET   = 6'b011011;

  int n_chk  = 0;
  int n_fail = 0;

  exc_ctrl dut (
    .clk(clk), .rst(rst), .pc_i(pc_i),
    .syscall_i(syscall_i), .break_i(break_i), .teq_i(teq_i), .eret_i(eret_i),
    .int_i(int_i), .status_i(status_i),
    .exc_o(exc_o), .eret_o(eret_o), .cause_o(cause_o), .epc_o(epc_o),
    .ack_o(ack_o), .stall_o(stall_o), .flush_o(flush_o), .busy_o(busy_o),
    .int_pend_o(int_pend_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; int_i = 6'h3f; syscall_i = 1'b1; pc_i = 32'hdead_beef;
    tick; tick;
    n_chk++; if (ctl !== C_IDLE) begin n_fail++; $display("FAIL rst_ctl: got %b want %b", ctl, C_IDLE); end
    n_chk++; if (cause_o !== 5'd0) begin n_fail++; $display("FAIL rst_cause: got %0d want 0", cause_o); end
    n_chk++; if (epc_o !== 32'h0) begin n_fail++; $display("FAIL rst_epc: got %h want 0", epc_o); end
    n_chk++; if (int_pend_o !== 6'h0) begin n_fail++; $display("FAIL rst_pend: got %b want 0", int_pend_o); end
    int_i = '0; syscall_i = 1'b0; pc_i = '0;
    rst = 1'b1;
    tick;
    n_chk++; if (ctl !== C_IDLE) begin n_fail++; $display("FAIL rst_rel_ctl: got %b want %b", ctl, C_IDLE); end
  endtask

  task automatic test_syscall;
    pc_i = 32'h0040_0010; syscall_i = 1'b1;
    tick;
    n_chk++; if (ctl !== C_ENT_S) begin n_fail++; $display("FAIL sys_enter_ctl: got %b want %b", ctl, C_ENT_S); end
    n_chk++; if (cause_o !== 5'd8) begin n_fail++; $display("FAIL sys_cause: got %0d want 8", cause_o); end
    n_chk++; if (epc_o !== 32'h0040_0010) begin n_fail++; $display("FAIL sys_epc: got %h want 00400010", epc_o); end
    syscall_i = 1'b0; pc_i = 32'h0040_0014;
    tick;
    n_chk++; if (ctl !== C_FLUSH) begin n_fail++; $display("FAIL sys_flush_ctl: got %b want %b", ctl, C_FLUSH); end
    n_chk++; if (epc_o !== 32'h0040_0010) begin n_fail++; $display("FAIL sys_epc_hold: got %h want 00400010", epc_o); end
    tick;
    n_chk++; if (ctl !== C_IDLE) begin n_fail++; $display("FAIL sys_idle_ctl: got %b want %b", ctl, C_IDLE); end
  endtask

  task automatic test_back_to_back;
    pc_i = 32'h0000_0100; syscall_i = 1'b1; break_i = 1'b1; teq_i = 1'b1;
    tick;
    n_chk++; if (ctl !== C_ENT_S) begin n_fail++; $display("FAIL b2b_enter1: got %b want %b", ctl, C_ENT_S); end
    n_chk++; if (cause_o !== 5'd8) begin n_fail++; $display("FAIL b2b_cause1: got %0d want 8", cause_o); end
    syscall_i = 1'b0;
    tick;
    n_chk++; if (ctl !== C_FLUSH) begin n_fail++; $display("FAIL b2b_flush1: got %b want %b", ctl, C_FLUSH); end
    n_chk++; if (cause_o !== 5'd8) begin n_fail++; $display("FAIL b2b_cause1_hold: got %0d want 8", cause_o); end
    tick;
    n_chk++; if (ctl !== C_IDLE) begin n_fail++; $display("FAIL b2b_idle1: got %b want %b", ctl, C_IDLE); end
    pc_i = 32'h0000_0104;
    tick;
    n_chk++; if (ctl !== C_ENT_S) begin n_fail++; $display("FAIL b2b_enter2: got %b want %b", ctl, C_ENT_S); end
    n_chk++; if (cause_o !== 5'd9) begin n_fail++; $display("FAIL b2b_cause2: got %0d want 9", cause_o); end
    n_chk++; if (epc_o !== 32'h0000_0104) begin n_fail++; $display("FAIL b2b_epc2: got %h want 00000104", epc_o); end
    break_i = 1'b0;
    tick; tick; tick;
    n_chk++; if (ctl !== C_ENT_S) begin n_fail++; $display("FAIL b2b_enter3: got %b want %b", ctl, C_ENT_S); end
    n_chk++; if (cause_o !== 5'd13) begin n_fail++; $display("FAIL b2b_cause3: got %0d want 13", cause_o); end
    teq_i = 1'b0;
    tick; tick;
    n_chk++; if (ctl !== C_IDLE) begin n_fail++; $display("FAIL b2b_idle3: got %b want %b", ctl, C_IDLE); end
  endtask

  task automatic test_interrupt;
    status_i = 32'h0000_0001; int_i = 6'b000100;
    tick;
    int_i = '0;
    n_chk++; if (int_pend_o !== 6'b000100) begin n_fail++; $display("FAIL int_latch: got %b want 000100", int_pend_o); end
    tick;
    n_chk++; if (ctl !== C_IDLE) begin n_fail++; $display("FAIL int_masked: got %b want %b", ctl, C_IDLE); end
    n_chk++; if (int_pend_o !== 6'b000100) begin n_fail++; $display("FAIL int_sticky: got %b want 000100", int_pend_o); end
    status_i = 32'h0000_1000; // unmasked but IE=0
    tick;
    n_chk++; if (ctl !== C_IDLE) begin n_fail++; $display("FAIL int_ie_off: got %b want %b", ctl, C_IDLE); end
    status_i = 32'h0000_1001; pc_i = 32'h0000_2000;
    tick;
    n_chk++; if (ctl !== C_ENT_I) begin n_fail++; $display("FAIL int_enter: got %b want %b", ctl, C_ENT_I); end
    n_chk++; if (cause_o !== 5'd0) begin n_fail++; $display("FAIL int_cause: got %0d want 0", cause_o); end
    n_chk++; if (epc_o !== 32'h0000_2000) begin n_fail++; $display("FAIL int_epc: got %h want 00002000", epc_o); end
    n_chk++; if (int_pend_o !== 6'b000000) begin n_fail++; $display("FAIL int_clear: got %b want 000000", int_pend_o); end
    tick;
    n_chk++; if (ctl !== C_FLUSH) begin n_fail++; $display("FAIL int_flush: got %b want %b", ctl, C_FLUSH); end
    tick;
    // Line held high through the entry: bit clears, then re-sets next cycle.
    int_i = 6'b000100; pc_i = 32'h0000_3000;
    tick;
    n_chk++; if (int_pend_o !== 6'b000100) begin n_fail++; $display("FAIL int_held_set: got %b want 000100", int_pend_o); end
    tick;
    n_chk++; if (ctl !== C_ENT_I) begin n_fail++; $display("FAIL int_held_enter: got %b want %b", ctl, C_ENT_I); end
    n_chk++; if (int_pend_o !== 6'b000000) begin n_fail++; $display("FAIL int_held_clr: got %b want 000000", int_pend_o); end
    tick;
    n_chk++; if (int_pend_o !== 6'b000100) begin n_fail++; $display("FAIL int_held_reset: got %b want 000100", int_pend_o); end
    int_i = '0; status_i = 32'h0;
    tick; tick;
    n_chk++; if (ctl !== C_IDLE) begin n_fail++; $display("FAIL int_idle: got %b want %b", ctl, C_IDLE); end
  endtask

  task automatic test_eret;
    pc_i = 32'h0000_0300; eret_i = 1'b1; break_i = 1'b1;
    tick;
    n_chk++; if (ctl !== C_ENT_S) begin n_fail++; $display("FAIL eret_brk_enter: got %b want %b", ctl, C_ENT_S); end
    n_chk++; if (cause_o !== 5'd9) begin n_fail++; $display("FAIL eret_brk_cause: got %0d want 9", cause_o); end
    break_i = 1'b0;
    tick;
    n_chk++; if (ctl !== C_FLUSH) begin n_fail++; $display("FAIL eret_brk_flush: got %b want %b", ctl, C_FLUSH); end
    tick;
    n_chk++; if (ctl !== C_IDLE) begin n_fail++; $display("FAIL eret_idle: got %b want %b", ctl, C_IDLE); end
    tick;
    n_chk++; if (ctl !== C_RET) begin n_fail++; $display("FAIL eret_ret: got %b want %b", ctl, C_RET); end
    eret_i = 1'b0;
    tick;
    n_chk++; if (ctl !== C_IDLE) begin n_fail++; $display("FAIL eret_done: got %b want %b", ctl, C_IDLE); end
    n_chk++; if (cause_o !== 5'd9) begin n_fail++; $display("FAIL eret_cause_hold: got %0d want 9", cause_o); end
    // Pending interrupt (bit2 left from earlier) loses to eret.
    status_i = 32'h0000_1001; eret_i = 1'b1; pc_i = 32'h0000_0400;
    tick;
    n_chk++; if (ctl !== C_RET) begin n_fail++; $display("FAIL eret_vs_int: got %b want %b", ctl, C_RET); end
    eret_i = 1'b0;
    tick;
    n_chk++; if (ctl !== C_IDLE) begin n_fail++; $display("FAIL eret_vs_int_idle: got %b want %b", ctl, C_IDLE); end
    tick;
    n_chk++; if (ctl !== C_ENT_I) begin n_fail++; $display("FAIL eret_then_int: got %b want %b", ctl, C_ENT_I); end
    status_i = 32'h0;
    tick; tick;
  endtask

  task automatic test_reset_mid;
    pc_i = 32'h0000_0500; syscall_i = 1'b1;
    tick;
    n_chk++; if (ctl !== C_ENT_S) begin n_fail++; $display("FAIL rmid_enter: got %b want %b", ctl, C_ENT_S); end
    rst = 1'b0; syscall_i = 1'b0;
    tick;
    n_chk++; if (ctl !== C_IDLE) begin n_fail++; $display("FAIL rmid_ctl: got %b want %b", ctl, C_IDLE); end
    n_chk++; if ({cause_o, epc_o, int_pend_o} !== '0) begin n_fail++; $display("FAIL rmid_regs: got %h/%h/%b want 0", cause_o, epc_o, int_pend_o); end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_chk++; if (ctl !== C_IDLE) begin n_fail++; $display("FAIL rmid_quiet%0d: got %b want %b", i, ctl, C_IDLE); end
    end
    // Request present on the first edge with reset released is taken.
    rst = 1'b0;
    tick;
    rst = 1'b1; teq_i = 1'b1; pc_i = 32'h0000_0600;
    tick;
    n_chk++; if (ctl !== C_ENT_S) begin n_fail++; $display("FAIL rrel_enter: got %b want %b", ctl, C_ENT_S); end
    n_chk++; if (cause_o !== 5'd13) begin n_fail++; $display("FAIL rrel_cause: got %0d want 13", cause_o); end
    teq_i = 1'b0;
    tick; tick;
    n_chk++; if (ctl !== C_IDLE) begin n_fail++; $display("FAIL rrel_idle: got %b want %b", ctl, C_IDLE); end
  endtask

  initial begin
    test_reset;
    test_syscall;
    test_back_to_back;
    test_interrupt;
    test_eret;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
